// File: rtl/load_store_unit_pkg.sv
// Shared core definitions: decoder opcodes, load/store size codes and LSU FSM states.
package load_store_unit_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Stores only have signed-size encodings; loads additionally allow BU/HU.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/half from a bus word and sign- or zero-extends it.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (byte_off)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = byte_off[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h000000, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0000, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one bus access per request, IDLE -> BUSY -> DONE, with bus timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    lsu_state_e     state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [2:0]     f3_q, f3_d;
    logic           we_q, we_d;
    logic [3:0]     wstrb_q, wstrb_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [CW-1:0]  wait_q, wait_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           timeout_q, timeout_d;

    logic           present, is_write, legal, mis, accept, expired;
    logic [3:0]     req_strb;
    logic [31:0]    req_lanes;
    logic [31:0]    load_data;

    assign present  = mem_read | mem_write;
    assign is_write = mem_write;
    assign legal    = f3_legal(funct3, is_write);
    assign mis      = legal & f3_misaligned(funct3, addr[1:0]);
    assign accept   = present & legal & !mis;
    assign expired  = !bus_ready && (wait_q == WAIT_LAST);

    // Strobes and replicated lane data for the incoming store; reads carry no strobes.
    always_comb begin
        req_strb  = 4'b0000;
        req_lanes = wdata;
        case (funct3)
            F3_B: begin
                req_strb  = 4'b0001 << addr[1:0];
                req_lanes = {4{wdata[7:0]}};
            end
            F3_H: begin
                req_strb  = addr[1] ? 4'b1100 : 4'b0011;
                req_lanes = {2{wdata[15:0]}};
            end
            default: req_strb = 4'b1111;
        endcase
        if (!is_write) begin
            req_strb = 4'b0000;
        end
    end

    load_extend u_load_extend (
        .funct3   (f3_q),
        .byte_off (addr_q[1:0]),
        .word     (bus_rdata),
        .data     (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (bus_ready || expired) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        misaligned = 1'b0;
        fault      = 1'b0;
        bus_req    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall      = accept;
                misaligned = present & mis;
                fault      = present & !legal;
            end
            ST_BUSY: begin
                stall   = 1'b1;
                bus_req = 1'b1;
            end
            default: fault = timeout_q;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        f3_d      = f3_q;
        we_d      = we_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        if (state_q == ST_IDLE && accept) begin
            addr_d    = addr;
            f3_d      = funct3;
            we_d      = is_write;
            wstrb_d   = req_strb;
            wdata_d   = req_lanes;
            wait_d    = '0;
            timeout_d = 1'b0;
        end else if (state_q == ST_BUSY) begin
            if (bus_ready) begin
                if (!we_q) rdata_d = load_data;
            end else if (expired) begin
                rdata_d   = 32'h0;
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= 32'h0;
            f3_q      <= 3'b000;
            we_q      <= 1'b0;
            wstrb_q   <= 4'b0000;
            wdata_q   <= 32'h0;
            wait_q    <= '0;
            rdata_q   <= 32'h0;
            timeout_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            f3_q      <= f3_d;
            we_q      <= we_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    assign rdata     = rdata_q;
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, misalignment, illegal codes, reset, timeout.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misaligned, fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    // Observations of the most recent access
    int          r_stalls;
    logic        r_done;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_wstrb;
    logic        r_we, r_fault, r_req;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misaligned (misaligned),
        .fault      (fault),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Issue one request; the responder answers after `waits` BUSY cycles (negative = never).
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int waits, input logic [31:0] brd);
        r_stalls = 0;
        r_done   = 1'b0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        if (stall) r_stalls++;
        for (int n = 0; n < 64; n++) begin
            @(posedge clk); #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            bus_ready = (n == waits);
            bus_rdata = brd;
            @(negedge clk);
            if (!stall) begin
                r_done  = 1'b1;
                r_rdata = rdata;
                r_fault = fault;
                r_req   = bus_req;
                break;
            end
            if (n == 0) begin
                r_addr  = bus_addr;
                r_we    = bus_we;
                r_wstrb = bus_wstrb;
                r_wdata = bus_wdata;
            end
            r_stalls++;
        end
        @(posedge clk); #1;
        bus_ready = 1'b0;
        check("access_completes", {31'b0, r_done}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("idle_flags", {29'b0, stall, misaligned, fault}, 32'h0);

        // LW, two wait cycles
        access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
        check("lw_bus_addr", r_addr, 32'h0000_0100);
        check("lw_bus_we", {31'b0, r_we}, 32'd0);
        check("lw_wstrb_zero", {28'b0, r_wstrb}, 32'h0);
        check("lw_stall_cycles", r_stalls, 32'd4);
        check("lw_rdata", r_rdata, 32'hDEAD_BEEF);
        check("lw_done_fault", {31'b0, r_fault}, 32'd0);
        check("lw_done_req", {31'b0, r_req}, 32'd0);

        // Byte and half loads, zero-wait responder
        access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h8012_3456);
        check("lb_rdata", r_rdata, 32'hFFFF_FF80);
        check("lb_stall_cycles", r_stalls, 32'd2);
        access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h8012_3456);
        check("lbu_rdata", r_rdata, 32'h0000_0080);
        access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 32'h8012_3456);
        check("lh_rdata", r_rdata, 32'hFFFF_8012);
        access(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 1, 32'h8012_F456);
        check("lhu_rdata", r_rdata, 32'h0000_F456);

        // Stores
        access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 0, 32'h0);
        check("sh_bus_we", {31'b0, r_we}, 32'd1);
        check("sh_bus_addr", r_addr, 32'h0000_0200);
        check("sh_bus_wstrb", {28'b0, r_wstrb}, 32'h0000_000C);
        check("sh_bus_wdata", r_wdata, 32'hABCD_ABCD);
        access(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678, 0, 32'h0);
        check("sb_bus_wstrb", {28'b0, r_wstrb}, 32'h0000_0002);
        check("sb_bus_wdata", r_wdata, 32'h7878_7878);
        // Read and write together: write wins
        access(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 0, 32'h0);
        check("rw_prio_we", {31'b0, r_we}, 32'd1);
        check("rw_prio_wstrb", {28'b0, r_wstrb}, 32'h0000_000F);
        check("rw_prio_wdata", r_wdata, 32'hCAFE_F00D);

        // Misaligned LW: no bus access
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0101;
        @(negedge clk);
        check("mis_flag", {31'b0, misaligned}, 32'd1);
        check("mis_stall", {31'b0, stall}, 32'd0);
        check("mis_fault", {31'b0, fault}, 32'd0);
        @(negedge clk);
        check("mis_no_req", {31'b0, bus_req}, 32'd0);
        // Illegal load funct3 and illegal store funct3
        @(posedge clk); #1;
        funct3 = 3'b011; addr = 32'h0000_0100;
        @(negedge clk);
        check("ill_load_fault", {31'b0, fault}, 32'd1);
        check("ill_load_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b100;
        @(negedge clk);
        check("ill_store_fault", {31'b0, fault}, 32'd1);
        check("ill_store_req", {30'b0, bus_req, stall}, 32'd0);
        @(posedge clk); #1;
        mem_write = 1'b0;
        @(negedge clk);
        check("idle_fault_clear", {29'b0, stall, misaligned, fault}, 32'h0);

        // Reset while BUSY, then a late bus_ready must be ignored
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100;
        @(posedge clk); #1;
        mem_read = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("pre_rst_busy_req", {31'b0, bus_req}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        check("rst_busy_req", {31'b0, bus_req}, 32'd0);
        check("rst_busy_stall", {31'b0, stall}, 32'd0);
        check("rst_busy_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        bus_ready = 1'b0;
        @(negedge clk);
        check("rst_late_ready_rdata", rdata, 32'h0);
        check("rst_late_ready_req", {31'b0, bus_req}, 32'd0);

        // Bus timeout: load that never completes; give rdata a nonzero history first
        access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 0, 32'h5555_AAAA);
        check("pre_timeout_rdata", r_rdata, 32'h5555_AAAA);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, -1, 32'hFFFF_FFFF);
        check("timeout_fault", {31'b0, r_fault}, 32'd1);
        check("timeout_rdata", r_rdata, 32'h0);
        check("timeout_req_low", {31'b0, r_req}, 32'd0);
        @(negedge clk);
        check("post_timeout_idle", {28'b0, bus_req, stall, misaligned, fault}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
